// File: rtl/msg_auth_pkg.sv
// Shared types for the message-authentication datapath.
// Block width and the FIFO entry layout {last, data}.
package msg_auth_pkg;

  localparam int BLOCK_W = 512;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef struct packed {
    logic   last;
    block_t data;
  } fifo_entry_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for msg_block_fifo: one write port,
// one asynchronous read port. Ports: clk, we/waddr/wdata, raddr/rdata.
module fifo_mem #(
  parameter int W     = 513,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msg_block_fifo.sv
// FWFT elastic buffer of message blocks with occupancy, message count,
// flush and sticky overflow flag.
// Ports: clk, reset, flush; in_valid/in_data/in_last/in_ready (ingress);
// out_valid/out_data/out_last/out_ready (to core); count, msg_count, err_ovf.
module msg_block_fifo
  import msg_auth_pkg::*;
#(
  parameter int DATA_WIDTH = BLOCK_W,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      msg_count,
  output logic                  err_ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] msg_q, msg_d;
  logic             err_q, err_d;

  logic              push, pop, we;
  logic [DATA_WIDTH:0] rd_entry;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign we        = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    msg_d    = msg_q;
    err_d    = err_q | (in_valid & ~in_ready);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      msg_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      msg_d   = msg_q + CNT_W'(push & in_last)
                      - CNT_W'(pop & out_last);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      msg_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      msg_q    <= msg_d;
      err_q    <= err_d;
    end
  end

  fifo_mem #(
    .W     (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({in_last, in_data}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_data  = rd_entry[DATA_WIDTH-1:0];
  assign out_last  = rd_entry[DATA_WIDTH];
  assign count     = count_q;
  assign msg_count = msg_q;
  assign err_ovf   = err_q;

endmodule
